// File: rtl/synthesizer.sv
// Composite-video sample synthesizer: palette index plus subcarrier phase to an 8-bit DAC code.
// Two registered stages: hue class, luma and offset phase, then sine lookup, level add and output.
module synthesizer (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] colourNum,
  input  logic [7:0] phase,
  output logic [7:0] video
);

  typedef enum logic [1:0] {
    CLS_BLACK,
    CLS_GREY,
    CLS_CHROMA
  } hue_class_t;

  localparam logic [7:0] BLACK_LEVEL = 8'd64;

  // Phase offset per hue, one 30 degree step per hue starting at hue 1.
  function automatic logic [7:0] hue_offset(input logic [3:0] hue);
    logic [7:0] off;
    case (hue)
      4'd1:    off = 8'd0;
      4'd2:    off = 8'd21;
      4'd3:    off = 8'd43;
      4'd4:    off = 8'd64;
      4'd5:    off = 8'd85;
      4'd6:    off = 8'd107;
      4'd7:    off = 8'd128;
      4'd8:    off = 8'd149;
      4'd9:    off = 8'd171;
      4'd10:   off = 8'd192;
      4'd11:   off = 8'd213;
      4'd12:   off = 8'd235;
      default: off = 8'd0;
    endcase
    return off;
  endfunction

  // Quarter-wave table: round(32*sin(2*pi*k/256)) for k = 0..64.
  function automatic logic [5:0] quarter_sine(input logic [6:0] k);
    logic [5:0] s;
    case (k)
      7'd0:                         s = 6'd0;
      7'd1:                         s = 6'd1;
      7'd2, 7'd3:                   s = 6'd2;
      7'd4:                         s = 6'd3;
      7'd5:                         s = 6'd4;
      7'd6, 7'd7:                   s = 6'd5;
      7'd8:                         s = 6'd6;
      7'd9:                         s = 6'd7;
      7'd10:                        s = 6'd8;
      7'd11, 7'd12:                 s = 6'd9;
      7'd13:                        s = 6'd10;
      7'd14:                        s = 6'd11;
      7'd15, 7'd16:                 s = 6'd12;
      7'd17:                        s = 6'd13;
      7'd18, 7'd19:                 s = 6'd14;
      7'd20:                        s = 6'd15;
      7'd21, 7'd22:                 s = 6'd16;
      7'd23:                        s = 6'd17;
      7'd24, 7'd25:                 s = 6'd18;
      7'd26:                        s = 6'd19;
      7'd27, 7'd28:                 s = 6'd20;
      7'd29, 7'd30:                 s = 6'd21;
      7'd31:                        s = 6'd22;
      7'd32, 7'd33:                 s = 6'd23;
      7'd34, 7'd35:                 s = 6'd24;
      7'd36, 7'd37:                 s = 6'd25;
      7'd38, 7'd39:                 s = 6'd26;
      7'd40, 7'd41, 7'd42:          s = 6'd27;
      7'd43, 7'd44:                 s = 6'd28;
      7'd45, 7'd46, 7'd47:          s = 6'd29;
      7'd48, 7'd49, 7'd50, 7'd51:   s = 6'd30;
      7'd52, 7'd53, 7'd54, 7'd55,
      7'd56:                        s = 6'd31;
      default:                      s = 6'd32;
    endcase
    return s;
  endfunction

  hue_class_t cls_in;
  hue_class_t cls_q;
  logic [1:0] luma_q;
  logic [7:0] p_q;

  always_comb begin
    cls_in = CLS_CHROMA;
    if (colourNum[3:0] == 4'd0)
      cls_in = CLS_GREY;
    else if (colourNum[3:0] >= 4'd13)
      cls_in = CLS_BLACK;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cls_q  <= CLS_BLACK;
      luma_q <= '0;
      p_q    <= '0;
    end else begin
      cls_q  <= cls_in;
      luma_q <= colourNum[5:4];
      p_q    <= phase + hue_offset(colourNum[3:0]);
    end
  end

  logic [6:0]        sine_idx;
  logic [5:0]        sine_mag;
  logic signed [6:0] sine_val;
  logic [7:0]        level;
  logic signed [9:0] sum;
  logic [7:0]        sample;

  // Fold the 256-step phase onto the quarter table: odd quadrants mirror, upper half negates.
  always_comb begin
    sine_idx = p_q[6] ? (7'd64 - {1'b0, p_q[5:0]}) : {1'b0, p_q[5:0]};
    sine_mag = quarter_sine(sine_idx);
    sine_val = p_q[7] ? -$signed({1'b0, sine_mag}) : $signed({1'b0, sine_mag});
  end

  always_comb begin
    level  = BLACK_LEVEL;
    sum    = '0;
    sample = BLACK_LEVEL;
    case (cls_q)
      CLS_GREY: begin
        case (luma_q)
          2'd0:    level = 8'd96;
          2'd1:    level = 8'd136;
          2'd2:    level = 8'd176;
          default: level = 8'd216;
        endcase
        sample = level;
      end
      CLS_CHROMA: begin
        case (luma_q)
          2'd0:    level = 8'd80;
          2'd1:    level = 8'd112;
          2'd2:    level = 8'd144;
          default: level = 8'd176;
        endcase
        sum = $signed({2'b00, level}) + {{3{sine_val[6]}}, sine_val};
        if (sum[9])
          sample = '0;
        else if (sum[8])
          sample = '1;
        else
          sample = sum[7:0];
      end
      default: sample = BLACK_LEVEL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      video <= BLACK_LEVEL;
    else
      video <= sample;
  end

endmodule

// File: tb/tb_synthesizer.sv
// Directed-vector and reference-model bench for the composite-video synthesizer.
module tb_synthesizer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] colourNum = 6'h2A;
  logic [7:0] phase = 8'd99;
  logic [7:0] video;

  int tests = 0;
  int fails = 0;

  synthesizer dut (
    .clk       (clk),
    .reset     (reset),
    .colourNum (colourNum),
    .phase     (phase),
    .video     (video)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] col;
    logic [7:0] ph;
    logic [7:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: video=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Drive inputs away from the edge, then sample just after the next rising edge.
  task automatic step(input logic r, input logic [5:0] c, input logic [7:0] p);
    @(negedge clk);
    reset     = r;
    colourNum = c;
    phase     = p;
    @(posedge clk);
    #1;
  endtask

  // Independent reference: real-valued sine with half-away rounding and computed offsets.
  function automatic logic [7:0] model(input logic [5:0] col, input logic [7:0] ph);
    int  hue, luma, off, pp, s, v;
    real x;
    int  grey_lv[4]   = '{96, 136, 176, 216};
    int  chroma_lv[4] = '{80, 112, 144, 176};
    hue  = int'(col[3:0]);
    luma = int'(col[5:4]);
    if (hue == 0) return 8'(grey_lv[luma]);
    if (hue >= 13) return 8'd64;
    off = ((hue - 1) * 512 + 12) / 24;
    pp  = (int'(ph) + off) % 256;
    x   = 32.0 * $sin(2.0 * 3.14159265358979 * pp / 256.0);
    if (x >= 0.0) s = $rtoi(x + 0.5);
    else          s = -$rtoi(-x + 0.5);
    v = chroma_lv[luma] + s;
    if (v < 0) v = 0;
    if (v > 255) v = 255;
    return 8'(v);
  endfunction

  initial begin
    vec_t vecs[$];
    logic [5:0] prev_c;
    logic [7:0] prev_p;
    logic       prev_r;
    logic [5:0] c;
    logic [7:0] p;
    logic       r;
    logic [7:0] e;

    vecs = '{
      '{6'h00, 8'd0,   8'd96},
      '{6'h10, 8'd77,  8'd136},
      '{6'h20, 8'd150, 8'd176},
      '{6'h30, 8'd255, 8'd216},
      '{6'h00, 8'd200, 8'd96},
      '{6'h0D, 8'd0,   8'd64},
      '{6'h1E, 8'd64,  8'd64},
      '{6'h3F, 8'd192, 8'd64},
      '{6'h01, 8'd0,   8'd80},
      '{6'h01, 8'd32,  8'd103},
      '{6'h01, 8'd64,  8'd112},
      '{6'h01, 8'd128, 8'd80},
      '{6'h01, 8'd192, 8'd48},
      '{6'h31, 8'd192, 8'd144},
      '{6'h37, 8'd192, 8'd208},
      '{6'h37, 8'd64,  8'd144},
      '{6'h37, 8'd200, 8'd207},
      '{6'h1C, 8'd85,  8'd144},
      '{6'h24, 8'd0,   8'd176},
      '{6'h0C, 8'd21,  8'd80}
    };

    // Reset with arbitrary inputs, then release: one more black sample before the first valid one.
    step(1'b1, 6'h30, 8'd64);
    check("reset_edge1", video, 8'd64);
    step(1'b1, 6'h30, 8'd64);
    check("reset_edge2", video, 8'd64);
    step(1'b0, 6'h30, 8'd64);
    check("release_edge1", video, 8'd64);
    step(1'b0, 6'h30, 8'd64);
    check("release_edge2", video, 8'd216);

    foreach (vecs[i]) begin
      step(1'b0, vecs[i].col, vecs[i].ph);
      step(1'b0, vecs[i].col, vecs[i].ph);
      check($sformatf("vec%0d_col%02h_ph%0d", i, vecs[i].col, vecs[i].ph), video, vecs[i].exp);
    end

    // Exact two-clock latency on a colour and phase change in the same cycle.
    step(1'b0, 6'h00, 8'd64);
    step(1'b0, 6'h00, 8'd64);
    check("lat_pre", video, 8'd96);
    step(1'b0, 6'h01, 8'd192);
    check("lat_edge1_old", video, 8'd96);
    step(1'b0, 6'h01, 8'd64);
    check("lat_edge2_new", video, 8'd48);
    step(1'b0, 6'h01, 8'd64);
    check("lat_next", video, 8'd112);

    // Sweep all colours with a free-running phase, with a single-cycle reset pulse mid-stream.
    prev_c = 6'h01;
    prev_p = 8'd64;
    prev_r = 1'b0;
    for (int i = 0; i < 660; i++) begin
      c = 6'((i / 10) % 64);
      p = 8'(i + 17);
      r = (i == 300);
      step(r, c, p);
      if (r || prev_r) e = 8'd64;
      else             e = model(prev_c, prev_p);
      check($sformatf("sweep%0d", i), video, e);
      if (!r && !prev_r && (video < 8'd48 || video > 8'd216)) begin
        tests++;
        fails++;
        $display("FAIL sweep_range%0d: video=%0d expected 48..216", i, video);
      end
      prev_c = c;
      prev_p = p;
      prev_r = r;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
